processor_fetch_queue: RTL and testbench
========================================

Name: processor_fetch_queue

Overview:
- Parametrised instruction-fetch stage with a prefetch queue.
- Issues in-order code reads ahead of decode and tolerates variable memory latency through a request/response handshake.
- Holds fetched words with their ip / ip+1 in a DEPTH-entry FIFO.
- On a redirect (call/jump), flushes the queue and discards stale in-flight responses. Sits between program memory and the decode stage.

Parameters:
- ADDR_SIZE, 18, code address width.
- WORD_SIZE, 18, instruction word width.
- DEPTH, 4, queue entries; power of two, 2..16.
- MAX_OUTSTANDING, 2, maximum in-flight memory reads; 1..DEPTH.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- code_addr  out  ADDR_SIZE  read address to program memory.
- code_req  out  1  read request valid.
- code_ack  in  1  memory accepted request this cycle.
- code_rdata  in  WORD_SIZE  returned instruction word.
- code_rvalid  in  1  response valid; responses return in request order.
- ip_to_call  in  ADDR_SIZE  redirect target.
- call_performed  in  1  redirect strobe, one cycle.
- out_valid  out  1  queue head valid.
- out_ready  in  1  decode consumes head (replaces no_operation).
- instr_out  out  WORD_SIZE  head instruction.
- ip_out  out  ADDR_SIZE  head address.
- ip_plus_one_out  out  ADDR_SIZE  head address + 1, wraps mod 2^ADDR_SIZE.

Behaviour:
- Reset (reset=0, async):
  - fetch_ip=0; rd/wr pointers=0; count=0; inflight=0; discard=0.
  - out_valid=0, code_req=0, instr_out=0, ip_out=0, ip_plus_one_out=0.
- code_addr = fetch_ip (combinational).
- code_req = 1 when count + inflight < DEPTH, inflight < MAX_OUTSTANDING, and call_performed=0.
- Request accepted (code_req & code_ack):
  - The fetch_ip of each accepted request is pushed to an internal address FIFO of depth MAX_OUTSTANDING.
  - inflight+1; fetch_ip+1 (wraps).
- Response (code_rvalid):
  - If discard>0: drop the response, discard-1, pop the address FIFO.
  - Else: write {rdata, addr, addr+1} at wr_ptr, count+1, pop the address FIFO.
  - inflight-1 in both cases.
  - code_rvalid with inflight=0 is an illegal-protocol event: ignored, counters unchanged.
- Output: registered, head of queue. out_valid = (count != 0).
- Handshake: pop when out_valid & out_ready; the next entry is visible the following cycle. Write-through of a response to the output in the same cycle is not allowed (minimum latency rvalid -> out_valid is 1 cycle).
- Simultaneous push and pop: count unchanged; both pointers advance.
- Full queue (count=DEPTH): no new requests; responses cannot overflow because requests are gated by count + inflight.
- Redirect (call_performed=1):
  - fetch_ip <= ip_to_call; count <= 0; pointers reset.
  - discard <= inflight minus any response arriving this cycle (that response is dropped).
  - out_valid falls next cycle.
  - A pop in the same cycle is ignored.
  - No request is issued in the redirect cycle; fetch from ip_to_call starts the next cycle.
- Back-to-back redirects: the latest target wins; discard is recomputed from current inflight.
- Pointer and address arithmetic wraps modulo the field width; no saturation.

Optional Feature:
- Macro: FETCH_QUEUE_STATS_EN.
- Defined: adds outputs stat_fetched [31:0] (entries popped by decode) and stat_flushed [31:0] (entries cleared plus responses discarded on redirect).
  - Both reset to 0 and wrap at 2^32.
  - Both update on the same edge as the triggering event.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Reset mid-stream: assert reset=0 with count=3, inflight=2 -> out_valid=0 and code_req=0 immediately; after release, first request has code_addr=0.
- Zero-wait memory (code_ack=1, rvalid one cycle after ack, data=addr^18'h2A), out_ready=1 -> instr_out sequence 0x2A,0x2B,0x28,... with ip_out 0,1,2,... and ip_plus_one_out = ip_out+1, one per cycle after fill.
- out_ready=0 with DEPTH=4 -> exactly 4 entries accepted, code_req=0 thereafter; release out_ready -> entries 0..3 popped in order, fetch resumes at 4.
- Redirect to 0x100 with inflight=2 and count=2 -> two subsequent responses dropped; next out_valid carries ip_out=0x100; with stats enabled, stat_flushed=4.
- Wrap: redirect to 0x3FFFF -> ip_out=0x3FFFF, ip_plus_one_out=0, next ip_out=0.
- Redirect in the same cycle as code_rvalid and out_ready pop -> response dropped, pop ignored, discard=inflight-1, queue empty next cycle.

Source files
------------

// File: rtl/processor_fetch_queue.sv
// -----------------------------------------------------------------------------
// processor_fetch_queue
//
// Instruction-fetch stage with a prefetch queue. It issues in-order reads to
// program memory ahead of decode and absorbs variable memory latency through a
// request/response handshake. Each returned word is queued together with its
// address and address+1. A redirect (call/jump) flushes the queue and marks
// the reads still in flight as stale, so their responses are dropped.
//
// Optional feature: define FETCH_QUEUE_STATS_EN to add the stat_fetched and
// stat_flushed counters and ports.
//
// Ports:
//   clock            in   system clock, rising edge
//   reset            in   asynchronous active-low reset
//   code_addr        out  program-memory read address (current fetch ip)
//   code_req         out  read request valid
//   code_ack         in   memory accepted the request this cycle
//   code_rdata       in   returned instruction word
//   code_rvalid      in   response valid; responses come back in request order
//   ip_to_call       in   redirect target
//   call_performed   in   one-cycle redirect strobe
//   out_valid        out  queue head valid (registered)
//   out_ready        in   decode consumes the head
//   instr_out        out  head instruction (registered)
//   ip_out           out  head address (registered)
//   ip_plus_one_out  out  head address + 1, modulo 2^ADDR_SIZE (registered)
//   stat_fetched     out  [FETCH_QUEUE_STATS_EN] entries popped by decode
//   stat_flushed     out  [FETCH_QUEUE_STATS_EN] entries and responses flushed
// -----------------------------------------------------------------------------
module processor_fetch_queue #(
    parameter int ADDR_SIZE       = 18,
    parameter int WORD_SIZE       = 18,
    parameter int DEPTH           = 4,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    output logic [ADDR_SIZE-1:0] code_addr,
    output logic                 code_req,
    input  logic                 code_ack,
    input  logic [WORD_SIZE-1:0] code_rdata,
    input  logic                 code_rvalid,
    input  logic [ADDR_SIZE-1:0] ip_to_call,
    input  logic                 call_performed,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WORD_SIZE-1:0] instr_out,
    output logic [ADDR_SIZE-1:0] ip_out,
    output logic [ADDR_SIZE-1:0] ip_plus_one_out
`ifdef FETCH_QUEUE_STATS_EN
    ,
    output logic [31:0]          stat_fetched,
    output logic [31:0]          stat_flushed
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = CW + 1;
    localparam int OW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int EW = WORD_SIZE + 2 * ADDR_SIZE;

    // Address-FIFO pointer increment; MAX_OUTSTANDING need not be a power of two.
    function automatic logic [OW-1:0] af_ptr_inc(input logic [OW-1:0] ptr);
        if (ptr == OW'(MAX_OUTSTANDING - 1)) begin
            return {OW{1'b0}};
        end else begin
            return ptr + 1'b1;
        end
    endfunction

    // State registers
    logic [ADDR_SIZE-1:0] fetch_ip_r;
    logic [PW-1:0]        rd_ptr_r;
    logic [PW-1:0]        wr_ptr_r;
    logic [CW-1:0]        count_r;
    logic [CW-1:0]        inflight_r;
    logic [CW-1:0]        discard_r;
    logic                 req_ok_r;
    logic [EW-1:0]        queue_mem_r [DEPTH];
    logic [ADDR_SIZE-1:0] addr_fifo_r [MAX_OUTSTANDING];
    logic [OW-1:0]        af_rd_r;
    logic [OW-1:0]        af_wr_r;
    logic                 out_valid_r;
    logic [WORD_SIZE-1:0] instr_r;
    logic [ADDR_SIZE-1:0] ip_r;
    logic [ADDR_SIZE-1:0] ip_plus_one_r;

    // Next-state / decode signals
    logic                 req_accept_s;
    logic                 rsp_legal_s;
    logic                 push_s;
    logic                 pop_s;
    logic [ADDR_SIZE-1:0] rsp_addr_s;
    logic [EW-1:0]        push_entry_s;
    logic [EW-1:0]        head_next_s;
    logic [PW-1:0]        rd_next_s;
    logic [PW-1:0]        wr_next_s;
    logic [CW-1:0]        count_next_s;
    logic [CW-1:0]        inflight_next_s;
    logic [CW-1:0]        discard_next_s;
    logic [ADDR_SIZE-1:0] fetch_next_s;
    logic [SW-1:0]        occupancy_next_s;
    logic                 req_ok_next_s;

    assign code_addr       = fetch_ip_r;
    // The request permission is precomputed from next-state occupancy; only the
    // redirect strobe gates it combinationally so no read is issued in that cycle.
    assign code_req        = req_ok_r & ~call_performed;
    assign out_valid       = out_valid_r;
    assign instr_out       = instr_r;
    assign ip_out          = ip_r;
    assign ip_plus_one_out = ip_plus_one_r;

    // Next-state computation for queue, in-flight tracking and head register.
    always_comb begin
        req_accept_s = code_req & code_ack;
        // A response with nothing in flight violates the protocol and is ignored.
        rsp_legal_s  = code_rvalid & (inflight_r != {CW{1'b0}});
        push_s       = rsp_legal_s & (discard_r == {CW{1'b0}}) & ~call_performed;
        pop_s        = out_valid_r & out_ready & ~call_performed;
        rsp_addr_s   = addr_fifo_r[af_rd_r];
        push_entry_s = {code_rdata, rsp_addr_s, rsp_addr_s + 1'b1};

        inflight_next_s = inflight_r + CW'(req_accept_s) - CW'(rsp_legal_s);

        if (call_performed) begin
            rd_next_s      = {PW{1'b0}};
            wr_next_s      = {PW{1'b0}};
            count_next_s   = {CW{1'b0}};
            fetch_next_s   = ip_to_call;
            // Every read still outstanding after this edge is stale, including
            // reads already marked for discard by an earlier redirect.
            discard_next_s = inflight_r - CW'(rsp_legal_s);
        end else begin
            rd_next_s    = rd_ptr_r + PW'(pop_s);
            wr_next_s    = wr_ptr_r + PW'(push_s);
            count_next_s = count_r + CW'(push_s) - CW'(pop_s);
            if (req_accept_s) begin
                fetch_next_s = fetch_ip_r + 1'b1;
            end else begin
                fetch_next_s = fetch_ip_r;
            end
            if (rsp_legal_s && (discard_r != {CW{1'b0}})) begin
                discard_next_s = discard_r - 1'b1;
            end else begin
                discard_next_s = discard_r;
            end
        end

        // When the queue is empty after a pop, the next head is the word being
        // written this cycle; it becomes visible one cycle after rvalid.
        if (push_s && (wr_ptr_r == rd_next_s)) begin
            head_next_s = push_entry_s;
        end else begin
            head_next_s = queue_mem_r[rd_next_s];
        end

        occupancy_next_s = SW'(count_next_s) + SW'(inflight_next_s);
        req_ok_next_s    = (occupancy_next_s < SW'(DEPTH)) &&
                           (inflight_next_s < CW'(MAX_OUTSTANDING));
    end

    // Fetch pointer, queue pointers, counters and registered head outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fetch_ip_r    <= {ADDR_SIZE{1'b0}};
            rd_ptr_r      <= {PW{1'b0}};
            wr_ptr_r      <= {PW{1'b0}};
            count_r       <= {CW{1'b0}};
            inflight_r    <= {CW{1'b0}};
            discard_r     <= {CW{1'b0}};
            req_ok_r      <= 1'b0;
            out_valid_r   <= 1'b0;
            instr_r       <= {WORD_SIZE{1'b0}};
            ip_r          <= {ADDR_SIZE{1'b0}};
            ip_plus_one_r <= {ADDR_SIZE{1'b0}};
        end else begin
            fetch_ip_r  <= fetch_next_s;
            rd_ptr_r    <= rd_next_s;
            wr_ptr_r    <= wr_next_s;
            count_r     <= count_next_s;
            inflight_r  <= inflight_next_s;
            discard_r   <= discard_next_s;
            req_ok_r    <= req_ok_next_s;
            out_valid_r <= (count_next_s != {CW{1'b0}});
            if (count_next_s != {CW{1'b0}}) begin
                instr_r       <= head_next_s[EW-1 -: WORD_SIZE];
                ip_r          <= head_next_s[2*ADDR_SIZE-1 -: ADDR_SIZE];
                ip_plus_one_r <= head_next_s[ADDR_SIZE-1:0];
            end else begin
                instr_r       <= instr_r;
                ip_r          <= ip_r;
                ip_plus_one_r <= ip_plus_one_r;
            end
        end
    end

    // Queue storage: one entry written per kept response.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                queue_mem_r[i] <= {EW{1'b0}};
            end
        end else begin
            if (push_s) begin
                queue_mem_r[wr_ptr_r] <= push_entry_s;
            end else begin
                queue_mem_r[wr_ptr_r] <= queue_mem_r[wr_ptr_r];
            end
        end
    end

    // Address FIFO pairing each response with the address of its request.
    // It is not cleared on redirect: stale responses still pop their entry.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                addr_fifo_r[i] <= {ADDR_SIZE{1'b0}};
            end
            af_rd_r <= {OW{1'b0}};
            af_wr_r <= {OW{1'b0}};
        end else begin
            if (req_accept_s) begin
                addr_fifo_r[af_wr_r] <= fetch_ip_r;
                af_wr_r              <= af_ptr_inc(af_wr_r);
            end else begin
                af_wr_r <= af_wr_r;
            end
            if (rsp_legal_s) begin
                af_rd_r <= af_ptr_inc(af_rd_r);
            end else begin
                af_rd_r <= af_rd_r;
            end
        end
    end

`ifdef FETCH_QUEUE_STATS_EN
    logic [31:0]   stat_fetched_r;
    logic [31:0]   stat_flushed_r;
    logic [SW-1:0] flush_amount_s;

    assign stat_fetched = stat_fetched_r;
    assign stat_flushed = stat_flushed_r;

    // Flushed work on a redirect: queued entries plus in-flight reads not
    // already counted as stale by an earlier redirect.
    always_comb begin
        if (call_performed) begin
            flush_amount_s = SW'(count_r) + SW'(inflight_r) - SW'(discard_r);
        end else begin
            flush_amount_s = {SW{1'b0}};
        end
    end

    // Free-running statistics counters, wrapping at 2^32.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stat_fetched_r <= 32'd0;
            stat_flushed_r <= 32'd0;
        end else begin
            stat_fetched_r <= stat_fetched_r + 32'(pop_s);
            stat_flushed_r <= stat_flushed_r + 32'(flush_amount_s);
        end
    end
`endif

endmodule

// File: tb/tb_processor_fetch_queue.sv
// -----------------------------------------------------------------------------
// Self-checking bench for processor_fetch_queue. The stimulus process drives
// the control inputs and a program-memory model (data = addr ^ 0x2A, response
// one cycle after acceptance, optional response budget to hold reads in
// flight). Expected head entries are queued by the stimulus; a separate monitor
// pops and compares on every decode handshake.
// -----------------------------------------------------------------------------
module tb_processor_fetch_queue;

    localparam int A = 18;
    localparam int W = 18;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic [A-1:0] code_addr;
    logic         code_req;
    logic         code_ack = 1'b0;
    logic [W-1:0] code_rdata = '0;
    logic         code_rvalid = 1'b0;
    logic [A-1:0] ip_to_call = '0;
    logic         call_performed = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] instr_out;
    logic [A-1:0] ip_out;
    logic [A-1:0] ip_plus_one_out;
`ifdef FETCH_QUEUE_STATS_EN
    logic [31:0]  stat_fetched;
    logic [31:0]  stat_flushed;
`endif

    processor_fetch_queue #(
        .ADDR_SIZE(A), .WORD_SIZE(W), .DEPTH(4), .MAX_OUTSTANDING(2)
    ) dut (
        .clock(clock), .reset(reset),
        .code_addr(code_addr), .code_req(code_req), .code_ack(code_ack),
        .code_rdata(code_rdata), .code_rvalid(code_rvalid),
        .ip_to_call(ip_to_call), .call_performed(call_performed),
        .out_valid(out_valid), .out_ready(out_ready),
        .instr_out(instr_out), .ip_out(ip_out), .ip_plus_one_out(ip_plus_one_out)
`ifdef FETCH_QUEUE_STATS_EN
        , .stat_fetched(stat_fetched), .stat_flushed(stat_flushed)
`endif
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [W-1:0] instr;
        logic [A-1:0] ip;
    } exp_t;

    exp_t         exp_q[$];
    logic [A-1:0] rsp_q[$];
    int           tests = 0;
    int           fails = 0;
    int           pops_since_reset = 0;
    int           acc_cnt = 0;
    int           rsp_budget = 1000;

    // Values applied at the next falling edge by step()
    logic         nx_rst = 1'b0;
    logic         nx_ack = 1'b0;
    logic         nx_rdy = 1'b0;
    logic         nx_call = 1'b0;
    logic [A-1:0] nx_target = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // One clock cycle: apply inputs at negedge, memory responds, record accepts.
    task automatic step();
        logic [A-1:0] a;
        @(negedge clock);
        reset          = nx_rst;
        code_ack       = nx_ack;
        out_ready      = nx_rdy;
        call_performed = nx_call;
        ip_to_call     = nx_target;
        if (!nx_rst) begin
            rsp_q.delete();
            code_rvalid = 1'b0;
            code_rdata  = '0;
        end else if (rsp_budget > 0 && rsp_q.size() > 0) begin
            a           = rsp_q.pop_front();
            code_rvalid = 1'b1;
            code_rdata  = a ^ 18'h0002A;
            rsp_budget--;
        end else begin
            code_rvalid = 1'b0;
            code_rdata  = '0;
        end
        #1;
        if (nx_rst && code_req && code_ack) begin
            rsp_q.push_back(code_addr);
            acc_cnt++;
        end
        #2;
    endtask

    task automatic push_exp(input logic [A-1:0] start, input int n);
        exp_t e;
        logic [A-1:0] ip;
        ip = start;
        for (int i = 0; i < n; i++) begin
            e.ip    = ip;
            e.instr = ip ^ 18'h0002A;
            exp_q.push_back(e);
            ip = ip + 18'd1;
        end
    endtask

    // Let decode consume until every expected entry has been seen, then stop.
    task automatic drain(input string name);
        int budget;
        budget = 200;
        while (exp_q.size() != 0 && budget > 0) begin
            step();
            budget--;
        end
        check(name, 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        nx_rdy = 1'b0;
        step();
    endtask

    task automatic do_reset();
        nx_rst = 1'b0;
        step();
        step();
        pops_since_reset = 0;
        acc_cnt = 0;
        nx_rst = 1'b1;
    endtask

    task automatic wait_first_req(input string name);
        int b;
        b = 0;
        while (!code_req && b < 10) begin
            step();
            b++;
        end
        check({name, "_seen"}, 64'(code_req), 64'd1);
        check({name, "_addr"}, 64'(code_addr), 64'd0);
    endtask

    // Scoreboard monitor: compare the head on every accepted decode pop.
    always begin : monitor
        exp_t         e;
        logic [A-1:0] exp1;
        @(negedge clock);
        #2;
        if (reset && out_valid && out_ready && !call_performed) begin
            tests++;
            pops_since_reset++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_pop: got ip %0h instr %0h, expected no entry", ip_out, instr_out);
            end else begin
                e    = exp_q.pop_front();
                exp1 = e.ip + 18'd1;
                if (instr_out !== e.instr || ip_out !== e.ip || ip_plus_one_out !== exp1) begin
                    fails++;
                    $display("FAIL head_entry: got instr %0h ip %0h ip1 %0h, expected instr %0h ip %0h ip1 %0h",
                             instr_out, ip_out, ip_plus_one_out, e.instr, e.ip, exp1);
                end
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        // Reset values
        step(); step(); step();
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_code_req", 64'(code_req), 64'd0);
        check("rst_instr", 64'(instr_out), 64'd0);
        check("rst_ip", 64'(ip_out), 64'd0);
        check("rst_ip1", 64'(ip_plus_one_out), 64'd0);
        nx_rst = 1'b1;
        step();
        wait_first_req("first_req");

        // Zero-wait streaming
        push_exp(18'h00000, 12);
        nx_ack = 1'b1;
        nx_rdy = 1'b1;
        drain("stream_drain");
        check("pre_reset_valid", 64'(out_valid), 64'd1);

        // Asynchronous reset in the middle of a stream
        reset  = 1'b0;
        nx_rst = 1'b0;
        rsp_q.delete();
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_code_req", 64'(code_req), 64'd0);
        nx_ack = 1'b0;
        do_reset();
        step();
        wait_first_req("post_rst_req");

        // Back-pressure: exactly DEPTH reads, then fetch resumes at 4
        acc_cnt = 0;
        nx_ack  = 1'b1;
        nx_rdy  = 1'b0;
        repeat (12) step();
        check("full_accepts", 64'(acc_cnt), 64'd4);
        check("full_code_req", 64'(code_req), 64'd0);
        check("full_out_valid", 64'(out_valid), 64'd1);
        check("full_head_ip", 64'(ip_out), 64'd0);
        check("full_head_instr", 64'(instr_out), 64'h2A);
        push_exp(18'h00000, 8);
        nx_rdy = 1'b1;
        drain("resume_drain");

        // Redirect with count=2, inflight=2
        do_reset();
        rsp_budget = 2;
        repeat (8) step();
        check("redir_setup_acc", 64'(acc_cnt), 64'd4);
        check("redir_setup_req", 64'(code_req), 64'd0);
        check("redir_setup_valid", 64'(out_valid), 64'd1);
        nx_call   = 1'b1;
        nx_target = 18'h00100;
        step();
        push_exp(18'h00100, 4);
        nx_call    = 1'b0;
        rsp_budget = 1000;
        nx_rdy     = 1'b1;
        step();
        check("redir_valid_falls", 64'(out_valid), 64'd0);
`ifdef FETCH_QUEUE_STATS_EN
        check("redir_stat_flushed", 64'(stat_flushed), 64'd4);
`endif
        drain("redir_drain");

        // Wrap of ip / ip+1 at the top of the address space
        nx_call   = 1'b1;
        nx_target = 18'h3FFFF;
        nx_rdy    = 1'b0;
        step();
        push_exp(18'h3FFFF, 3);
        nx_call = 1'b0;
        nx_rdy  = 1'b1;
        drain("wrap_drain");

        // Redirect coinciding with a response and a decode pop
        do_reset();
        rsp_budget = 2;
        repeat (8) step();
        check("same_setup_valid", 64'(out_valid), 64'd1);
        nx_call    = 1'b1;
        nx_target  = 18'h00200;
        nx_rdy     = 1'b1;
        rsp_budget = 1000;
        step();
        push_exp(18'h00200, 3);
        nx_call = 1'b0;
        step();
        check("same_cycle_empty", 64'(out_valid), 64'd0);
        drain("same_drain");
`ifdef FETCH_QUEUE_STATS_EN
        check("final_stat_fetched", 64'(stat_fetched), 64'(pops_since_reset));
        check("final_stat_flushed", 64'(stat_flushed), 64'd4);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
